// File: rtl/matrix_chain_driver_pkg.sv
// Shared types and helpers for the LED panel chain driver.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package matrix_chain_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DWELL    = 3'd5
    } state_t;

    localparam int BITS_PER_PANEL = 16;
    localparam int ROWS           = 8;

    // Row select byte: bit r drives row r, active-high.
    function automatic logic [7:0] row_onehot(input logic [2:0] row);
        return 8'd1 << row;
    endfunction

    // One panel's 16 shifted bits: column byte (optionally inverted) then row byte.
    function automatic logic [15:0] panel_word(input logic [7:0] pix,
                                               input logic [2:0] row,
                                               input logic       col_active_low);
        logic [7:0] col;
        col = col_active_low ? ~pix : pix;
        return {col, row_onehot(row)};
    endfunction

endpackage

// File: rtl/matrix_chain_driver_if.sv
// Control, frame-write and panel-pin bundle for the LED panel chain driver.
// Latency: n/a (wires only).
// Backpressure: none; writes and swap requests are accepted unconditionally.
interface matrix_chain_driver_if #(
    parameter int PANELS = 2
);
    localparam int PW = (PANELS > 1) ? $clog2(PANELS) : 1;

    logic          enable;
    logic [1:0]    refresh_speed;
    logic          wr_en;
    logic [PW-1:0] wr_panel;
    logic [2:0]    wr_row;
    logic [7:0]    wr_data;
    logic          swap_req;
    logic          swap_pending;
    logic          frame_start;
    logic          matrix_clk;
    logic          matrix_latch;
    logic          matrix_mosi;

    // Board side: drives control and frame writes, observes status and pins.
    modport master (
        output enable, refresh_speed, wr_en, wr_panel, wr_row, wr_data, swap_req,
        input  swap_pending, frame_start, matrix_clk, matrix_latch, matrix_mosi
    );

    // Driver side.
    modport slave (
        input  enable, refresh_speed, wr_en, wr_panel, wr_row, wr_data, swap_req,
        output swap_pending, frame_start, matrix_clk, matrix_latch, matrix_mosi
    );

endinterface

// File: rtl/matrix_chain_driver_fb.sv
// Double-buffered frame store: 2 banks x PANELS x 8 rows x 8 pixels.
// Latency: write commits in 1 cycle; row read is registered (1 cycle), with write-through forwarding.
// Backpressure: none; one write and one full-row read every cycle.
module matrix_chain_driver_fb
    import matrix_chain_driver_pkg::*;
#(
    parameter int PANELS = 2,
    parameter int PW     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic                   wr_bank,
    input  logic [PW-1:0]          wr_panel,
    input  logic [2:0]             wr_row,
    input  logic [7:0]             wr_data,
    input  logic                   rd_bank,
    input  logic [2:0]             rd_row,
    output logic [PANELS-1:0][7:0] rd_data
);

    logic [7:0]             mem_q [2][PANELS][ROWS];
    logic [PANELS-1:0][7:0] rd_data_d;
    logic [PANELS-1:0][7:0] rd_data_q;

    // Pixel storage; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_panel][wr_row] <= wr_data;
        end
    end

    // Read all panels of one row; a same-edge write to that location is forwarded
    // so a write landing in the bank that becomes front shows up at once.
    always_comb begin
        rd_data_d = '0;
        for (int p = 0; p < PANELS; p++) begin
            if (wr_en && (wr_bank == rd_bank) && (wr_row == rd_row) &&
                (wr_panel == PW'(p))) begin
                rd_data_d[p] = wr_data;
            end else begin
                rd_data_d[p] = mem_q[rd_bank][p][rd_row];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/matrix_chain_driver.sv
// Row-scanning serial driver for a daisy chain of 8x8 LED panels (two 595s each).
// Latency: row step = 1 + 2*CLK_DIV*PANELS*16 + CLK_DIV + dwell cycles; all pins registered.
// Backpressure: none; enable=0 stops at the next row boundary, swaps wait for frame end.
module matrix_chain_driver
    import matrix_chain_driver_pkg::*;
#(
    parameter int PANELS         = 2,
    parameter int CLK_DIV        = 50,
    parameter int BASE_DWELL     = 1000,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    matrix_chain_driver_if.slave  bus
);

    localparam int PW    = (PANELS > 1) ? $clog2(PANELS) : 1;
    localparam int NBITS = PANELS * BITS_PER_PANEL;
    localparam int BIT_W = $clog2(NBITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DWL_W = $clog2(BASE_DWELL * 64 + 1);

    state_t             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic               front_q, front_d;
    logic               swap_pend_q, swap_pend_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DWL_W-1:0]   dwell_len_q, dwell_len_d;
    logic [DWL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic               frame_start_q, frame_start_d;
    logic               mclk_q, mclk_d;
    logic               latch_q, latch_d;
    logic               mosi_q, mosi_d;

    logic                   div_last;
    logic                   wr_ok;
    logic [PANELS-1:0][7:0] fb_rd;
    logic [NBITS-1:0]       load_vec;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign wr_ok    = bus.wr_en && (32'(bus.wr_panel) < PANELS);

    // Read address follows the next row/bank so the data is ready during LOAD.
    matrix_chain_driver_fb #(
        .PANELS (PANELS),
        .PW     (PW)
    ) u_fb (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_ok),
        .wr_bank  (~front_q),
        .wr_panel (bus.wr_panel),
        .wr_row   (bus.wr_row),
        .wr_data  (bus.wr_data),
        .rd_bank  (front_d),
        .rd_row   (row_d),
        .rd_data  (fb_rd)
    );

    // Assemble one row step; the highest panel index is furthest and goes out first.
    always_comb begin
        load_vec = '0;
        for (int p = 0; p < PANELS; p++) begin
            load_vec[p*BITS_PER_PANEL +: BITS_PER_PANEL] =
                panel_word(fb_rd[p], row_q, COL_ACTIVE_LOW != 0);
        end
    end

    // Scan sequencing, bank swap at frame end, and next values of the registered pins.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        front_d     = front_q;
        div_d       = div_q;
        bit_d       = bit_q;
        dwell_len_d = dwell_len_q;
        dwell_cnt_d = dwell_cnt_q;
        shift_d     = shift_q;
        swap_pend_d = swap_pend_q | bus.swap_req;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dwell_len_d = DWL_W'(BASE_DWELL) << (2 * bus.refresh_speed);
                shift_d     = load_vec;
                bit_d       = '0;
                div_d       = '0;
                state_d     = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_W'(NBITS - 1)) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {shift_q[NBITS-2:0], 1'b0};
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_last) begin
                    div_d       = '0;
                    dwell_cnt_d = dwell_len_q - DWL_W'(1);
                    state_d     = ST_DWELL;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DWELL: begin
                if (dwell_cnt_q == '0) begin
                    row_d = row_q + 3'd1;
                    // Frame end: apply an accepted swap; a request arriving now waits a frame.
                    if (row_q == 3'd7 && swap_pend_q) begin
                        front_d     = ~front_q;
                        swap_pend_d = bus.swap_req;
                    end
                    state_d = bus.enable ? ST_LOAD : ST_IDLE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        frame_start_d = (state_d == ST_LOAD) && (row_d == 3'd0);
        mclk_d        = (state_d == ST_SHIFT_HI);
        latch_d       = (state_d == ST_LATCH);
        mosi_d        = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ?
                        shift_d[NBITS-1] : 1'b0;
    end

    // State and pin registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            front_q       <= 1'b0;
            swap_pend_q   <= 1'b0;
            div_q         <= '0;
            bit_q         <= '0;
            dwell_len_q   <= '0;
            dwell_cnt_q   <= '0;
            shift_q       <= '0;
            frame_start_q <= 1'b0;
            mclk_q        <= 1'b0;
            latch_q       <= 1'b0;
            mosi_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            front_q       <= front_d;
            swap_pend_q   <= swap_pend_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            dwell_len_q   <= dwell_len_d;
            dwell_cnt_q   <= dwell_cnt_d;
            shift_q       <= shift_d;
            frame_start_q <= frame_start_d;
            mclk_q        <= mclk_d;
            latch_q       <= latch_d;
            mosi_q        <= mosi_d;
        end
    end

    assign bus.swap_pending = swap_pend_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.matrix_clk   = mclk_q;
    assign bus.matrix_latch = latch_q;
    assign bus.matrix_mosi  = mosi_q;

endmodule

// File: tb/tb_matrix_chain_driver.sv
// Directed bench for the LED panel chain driver (PANELS=2, CLK_DIV=2, BASE_DWELL=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_chain_driver;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    matrix_chain_driver_if #(.PANELS(2)) bus ();

    matrix_chain_driver #(
        .PANELS         (2),
        .CLK_DIV        (2),
        .BASE_DWELL     (4),
        .COL_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  p1;
        logic [7:0]  p0;
        logic [2:0]  row;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    int n_tests = 0;
    int n_fail  = 0;

    // Pin monitor state.
    logic [31:0] mon_word   = '0;
    int          mon_edges  = 0;
    int          clk_edges  = 0;
    int          lat_len    = 0;
    int          cyc        = 0;
    int          fs_count   = 0;
    logic        prev_mclk  = 1'b0;
    logic        prev_latch = 1'b0;
    logic [31:0] lat_word [$];
    int          lat_edges [$];
    int          lat_time [$];
    int          lat_lens [$];

    // Collect mosi on each rising shift clock and record every latch pulse.
    always @(negedge clk) begin
        cyc++;
        if (bus.matrix_clk && !prev_mclk) begin
            mon_word = {mon_word[30:0], bus.matrix_mosi};
            mon_edges++;
            clk_edges++;
        end
        if (bus.matrix_latch && !prev_latch) begin
            lat_word.push_back(mon_word);
            lat_edges.push_back(mon_edges);
            lat_time.push_back(cyc);
            mon_edges = 0;
            lat_len   = 0;
        end
        if (bus.matrix_latch) lat_len++;
        if (!bus.matrix_latch && prev_latch) lat_lens.push_back(lat_len);
        if (bus.frame_start) fs_count++;
        prev_mclk  = bus.matrix_clk;
        prev_latch = bus.matrix_latch;
    end

    function automatic logic [31:0] word_at(input int i);
        if (i >= 0 && i < lat_word.size()) return lat_word[i];
        return 32'hDEADBEEF;
    endfunction

    function automatic int edges_at(input int i);
        if (i >= 0 && i < lat_edges.size()) return lat_edges[i];
        return -1;
    endfunction

    function automatic int time_at(input int i);
        if (i >= 0 && i < lat_time.size()) return lat_time[i];
        return -100000;
    endfunction

    function automatic int lens_at(input int i);
        if (i >= 0 && i < lat_lens.size()) return lat_lens[i];
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic p, input logic [2:0] r, input logic [7:0] d);
        bus.wr_en    = 1'b1;
        bus.wr_panel = p;
        bus.wr_row   = r;
        bus.wr_data  = d;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic wait_lat(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (lat_word.size() < n && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("%s_latch_count", nm), lat_word.size(), n);
    endtask

    task automatic wait_row_latch(input logic [7:0] rb, input int budget, input string nm);
        int          seen;
        int          k;
        logic        found;
        logic [31:0] w;
        seen  = lat_word.size();
        found = 1'b0;
        k     = 0;
        while (!found && k < budget) begin
            tick();
            k++;
            if (lat_word.size() > seen) begin
                seen = lat_word.size();
                w    = word_at(seen - 1);
                if (w[7:0] == rb) found = 1'b1;
            end
        end
        check(nm, found, 1);
    endtask

    initial begin
        int          base;
        int          k;
        int          e0;
        int          f0;
        logic        found;
        logic [31:0] w;

        tbl[0] = '{p1: 8'hA5, p0: 8'h3C, row: 3'd0, exp: 32'h5A01C301};
        tbl[1] = '{p1: 8'hFF, p0: 8'h00, row: 3'd1, exp: 32'h0002FF02};
        tbl[2] = '{p1: 8'h00, p0: 8'hFF, row: 3'd2, exp: 32'hFF040004};
        tbl[3] = '{p1: 8'h81, p0: 8'h18, row: 3'd3, exp: 32'h7E08E708};
        tbl[4] = '{p1: 8'h0F, p0: 8'hF0, row: 3'd4, exp: 32'hF0100F10};
        tbl[5] = '{p1: 8'h55, p0: 8'hAA, row: 3'd5, exp: 32'hAA205520};
        tbl[6] = '{p1: 8'h01, p0: 8'h80, row: 3'd6, exp: 32'hFE407F40};
        tbl[7] = '{p1: 8'hC3, p0: 8'h7E, row: 3'd7, exp: 32'h3C808180};

        bus.enable        = 1'b1;
        bus.refresh_speed = 2'd0;
        bus.wr_en         = 1'b0;
        bus.wr_panel      = '0;
        bus.wr_row        = 3'd0;
        bus.wr_data       = 8'h00;
        bus.swap_req      = 1'b0;

        // Reset held with enable high: everything quiet.
        repeat (10) tick();
        check("reset_outputs", {bus.swap_pending, bus.frame_start, bus.matrix_clk,
                                bus.matrix_latch, bus.matrix_mosi}, 0);
        check("reset_no_clk_edges", clk_edges, 0);

        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            tick();
            if (bus.frame_start) found = 1'b1;
        end
        check("first_frame_start", found, 1);

        // Fill the back bank from the table, then request a swap.
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, tbl[i].row, tbl[i].p1);
            wr(1'b0, tbl[i].row, tbl[i].p0);
        end
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        check("swap_pending_set", bus.swap_pending, 1);
        k = 0;
        while (bus.swap_pending && k < 2500) begin
            tick();
            k++;
        end
        check("swap_pending_clear", bus.swap_pending, 0);

        base = lat_word.size();
        wait_lat(base + 8, 1300, "frame_a");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("row%0d_word", i), word_at(base + i), tbl[i].exp);
            check($sformatf("row%0d_edges", i), edges_at(base + i), 32);
        end
        check("latch_width", lens_at(lat_lens.size() - 1), 2);
        check("row_period", time_at(base + 1) - time_at(base), 135);

        // Dwell change mid-shift of row 0 applies from row 1 onward.
        f0 = fs_count;
        k  = 0;
        while (fs_count == f0 && k < 200) begin
            tick();
            k++;
        end
        check("frame_start_seen", fs_count - f0, 1);
        base = lat_word.size();
        repeat (10) tick();
        bus.refresh_speed = 2'd3;
        wait_lat(base + 3, 1000, "dwell_slow");
        bus.refresh_speed = 2'd0;
        wait_lat(base + 5, 1000, "dwell_fast");
        check("period_row0_old_dwell", time_at(base + 1) - time_at(base), 135);
        check("period_row1_dwell256", time_at(base + 2) - time_at(base + 1), 387);
        check("period_row2_dwell256", time_at(base + 3) - time_at(base + 2), 387);
        check("period_row3_restored", time_at(base + 4) - time_at(base + 3), 135);

        // Two swap requests in one frame, plus a write in the swap cycle.
        wr(1'b1, 3'd0, 8'h11);
        wr(1'b0, 3'd0, 8'h22);
        wr(1'b1, 3'd1, 8'h33);
        wr(1'b0, 3'd1, 8'h44);
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        check("double_swap_pending", bus.swap_pending, 1);
        wait_row_latch(8'h80, 1500, "row7_latch_seen");
        repeat (5) tick();
        check("pending_before_frame_end", bus.swap_pending, 1);
        bus.wr_en    = 1'b1;
        bus.wr_panel = 1'b1;
        bus.wr_row   = 3'd0;
        bus.wr_data  = 8'hE7;
        tick();
        bus.wr_en    = 1'b0;
        check("pending_after_frame_end", bus.swap_pending, 0);
        base = lat_word.size();
        wait_lat(base + 2, 400, "swap_b");
        check("swap_cycle_write_row0", word_at(base), 32'h1801DD01);
        check("swapped_row1", word_at(base + 1), 32'hCC02BB02);
        wait_lat(base + 9, 1300, "frame_c");
        check("single_toggle_row0", word_at(base + 8), 32'h1801DD01);
        check("no_queued_swap", bus.swap_pending, 0);

        // Stop mid-shift of row 3, then resume at row 4.
        wait_row_latch(8'h04, 1500, "row2_latch_seen");
        repeat (20) tick();
        bus.enable = 1'b0;
        wait_row_latch(8'h08, 400, "row3_completes");
        repeat (20) tick();
        e0 = clk_edges;
        f0 = fs_count;
        base = lat_word.size();
        repeat (300) tick();
        check("idle_no_clk_edges", clk_edges - e0, 0);
        check("idle_no_latch", lat_word.size() - base, 0);
        check("idle_outputs", {bus.frame_start, bus.matrix_clk, bus.matrix_latch,
                               bus.matrix_mosi}, 0);
        bus.enable = 1'b1;
        wait_lat(base + 1, 300, "resume");
        w = word_at(base);
        check("resume_row4", w & 32'h00FF00FF, 32'h00100010);
        check("resume_no_frame_start", fs_count - f0, 0);

        // Reset asserted in SHIFT_HI drops the shift clock without a clock edge.
        k = 0;
        while (!bus.matrix_clk && k < 200) begin
            tick();
            k++;
        end
        check("shift_hi_reached", bus.matrix_clk, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_pins", {bus.matrix_clk, bus.matrix_latch, bus.matrix_mosi}, 0);

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
